// File: rtl/karlsen_pkg.sv
// Shared arithmetic definitions for the Karlsen ladder filters: word type,
// saturation limits, clamp helpers and the high-pass sequencer states.
package karlsen_pkg;

  localparam int WMULT = 18;

  typedef logic signed [WMULT-1:0] word_t;

  typedef enum logic [3:0] {
    ST_MIX  = 4'd0,
    ST_SUB  = 4'd1,
    ST_SAT  = 4'd2,
    ST_LD1  = 4'd3,
    ST_P1   = 4'd4,
    ST_P2   = 4'd5,
    ST_P3   = 4'd6,
    ST_P4   = 4'd7,
    ST_IDLE = 4'd8
  } hpf_state_t;

  function automatic int sat_max(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 <<< (w - 1));
  endfunction

  // Saturate an internal word to the signed range of a w-bit sample.
  function automatic word_t clamp(input word_t x, input int w);
    if (int'(x) > sat_max(w)) return word_t'(sat_max(w));
    if (int'(x) < sat_min(w)) return word_t'(sat_min(w));
    return x;
  endfunction

  function automatic word_t clamp_pos(input word_t x);
    return (x < 0) ? '0 : x;
  endfunction

endpackage

// File: rtl/smul_shift_18x18.sv
// Shared interpolating multiply: o = a + ((b - a) * scale) >>> 16.
module smul_shift_18x18
  import karlsen_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t scale,
  output word_t o
);

  word_t                       diff;
  logic signed [2*WMULT-1:0]   prod;

  assign diff = b - a;
  assign prod = diff * scale;
  assign o    = a + $signed(prod[WMULT+15:16]);

endmodule

// File: rtl/karlsen_hpf_pipelined.sv
// Four-pole Karlsen high-pass filter: one shared multiplier sequenced over
// eight clk cycles per sample, started by each sample_clk toggle.
module karlsen_hpf_pipelined
  import karlsen_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic signed [W-1:0] g,
  input  logic signed [W-1:0] resonance,
  input  logic signed [W-1:0] sample_in,
  output logic signed [W-1:0] sample_out,
  output logic                out_valid,
  output logic                busy
);

  hpf_state_t state_q, state_d;
  logic       sclk_q;
  logic       toggle;

  word_t op_a, op_b, op_scale, mul_o;
  word_t x0, lp1, lp2, lp3, lp4, hp1, hp2, hp3;
  word_t in_x, y_prev, g_ex, res_ex;
  word_t sub_src, hp_new;

  assign in_x   = word_t'(sample_in);
  assign y_prev = word_t'(sample_out);
  assign g_ex   = clamp_pos(word_t'(g));
  assign res_ex = clamp_pos(word_t'(resonance)) <<< 2;
  assign toggle = (sample_clk != sclk_q);
  assign busy   = (state_q != ST_IDLE);

  smul_shift_18x18 u_mul (
    .a     (op_a),
    .b     (op_b),
    .scale (op_scale),
    .o     (mul_o)
  );

  // High-pass tap of the stage whose low-pass result is on the multiplier now.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sub_src = x0;
    case (state_q)
      ST_P2:   sub_src = hp1;
      ST_P3:   sub_src = hp2;
      ST_P4:   sub_src = hp3;
      default: sub_src = x0;
    endcase
    hp_new = clamp(sub_src - mul_o, W);
  end

  always_comb begin
    state_d = state_q;
    if (toggle)                 state_d = ST_MIX;
    else if (state_q != ST_IDLE) state_d = hpf_state_t'(state_q + 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sclk_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      sclk_q  <= sample_clk;
    end
  end

  // A toggle restarts the sequence; stages already committed keep their state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_scale   <= '0;
      x0         <= '0;
      lp1        <= '0;
      lp2        <= '0;
      lp3        <= '0;
      lp4        <= '0;
      hp1        <= '0;
      hp2        <= '0;
      hp3        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!toggle) begin
        case (state_q)
          ST_MIX: begin
            op_a     <= in_x;
            op_b     <= y_prev;
            op_scale <= res_ex;
          end
          ST_SUB: x0 <= (in_x <<< 1) - mul_o;
          ST_SAT: x0 <= clamp(x0, W);
          ST_LD1: begin
            op_a     <= lp1;
            op_b     <= x0;
            op_scale <= g_ex;
          end
          ST_P1: begin
            lp1  <= mul_o;
            hp1  <= hp_new;
            op_a <= lp2;
            op_b <= hp_new;
          end
          ST_P2: begin
            lp2  <= mul_o;
            hp2  <= hp_new;
            op_a <= lp3;
            op_b <= hp_new;
          end
          ST_P3: begin
            lp3  <= mul_o;
            hp3  <= hp_new;
            op_a <= lp4;
            op_b <= hp_new;
          end
          ST_P4: begin
            lp4        <= mul_o;
            sample_out <= hp_new[W-1:0];
            out_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_karlsen_hpf_pipelined.sv
// Directed bench for karlsen_hpf_pipelined with hand-computed expected outputs.
module tb_karlsen_hpf_pipelined;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sample_clk = 1'b0;
  logic signed [W-1:0] g = '0;
  logic signed [W-1:0] resonance = '0;
  logic signed [W-1:0] sample_in = '0;
  logic signed [W-1:0] sample_out;
  logic                out_valid;
  logic                busy;

  int checks = 0;
  int errors = 0;

  karlsen_hpf_pipelined #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_clk (sample_clk),
    .g          (g),
    .resonance  (resonance),
    .sample_in  (sample_in),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    sample_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Toggle sample_clk, optionally toggle again before edge E+abort_at, and
  // watch 14 edges for exactly one out_valid pulse carrying exp.
  task automatic run_sample(input string tag, input int abort_at, input int exp);
    int                 pulses = 0;
    int                 pulse_k = -1;
    logic signed [31:0] val = 0;
    @(negedge clk);
    sample_clk = ~sample_clk;
    @(posedge clk);
    #1;
    check({tag, "_busy_start"}, busy, 1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == abort_at) sample_clk = ~sample_clk;
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        pulse_k = k;
        val     = sample_out;
      end
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_latency"}, pulse_k, (abort_at > 0) ? abort_at + 8 : 8);
    check({tag, "_value"}, val, exp);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int stray_valid;
    int stray_busy;
    g         = 16'sd16384;
    resonance = 16'sd0;
    sample_in = 16'sd16384;

    repeat (2) @(negedge clk);
    check("rst_sample_out", sample_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Step response from a cleared filter.
    run_sample("step1", 0, 5184);
    run_sample("step2", 0, 0);
    run_sample("step3", 0, -1944);

    // Async reset in the middle of a sample (sample_clk falls to 0 at E).
    @(negedge clk);
    sample_clk = ~sample_clk;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("arst_busy_before", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_sample_out", sample_out, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n       = 1'b1;
    stray_valid = 0;
    stray_busy  = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) stray_valid++;
      if (busy) stray_busy++;
    end
    check("arst_no_resume_valid", stray_valid, 0);
    check("arst_no_resume_busy", stray_busy, 0);
    check("arst_hold_out", sample_out, 0);
    run_sample("after_arst", 0, 5184);

    // Zero and negative cutoff pass the driven stage straight through.
    apply_reset();
    g         = 16'sd0;
    sample_in = -16'sd32768;
    run_sample("zero_g", 0, -32768);
    g = -16'sd5;
    run_sample("neg_g", 0, -32768);

    // Maximum resonance drives x0 past full scale.
    apply_reset();
    g         = 16'sd0;
    resonance = 16'sd32767;
    sample_in = 16'sd32767;
    run_sample("clamp", 0, 32767);

    // Abort at E+4: only the restarted sample produces a result.
    apply_reset();
    g         = 16'sd16384;
    resonance = 16'sd0;
    sample_in = 16'sd16384;
    run_sample("abort", 4, 5184);
    run_sample("post_abort", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
